// File: rtl/key_event_if.sv
// Event handshake between the key event generator and its consumer.
interface key_event_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_code;

    modport master (
        output ev_valid,
        output ev_code,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        output ev_ready
    );
endinterface

// File: rtl/key_event.sv
// Key press / release / long-press / auto-repeat event generator with a
// single-entry event register and sticky overflow flag.
module key_event #(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            i,
    input  logic            ovf_clr,
    key_event_if.master     ev,
    output logic            held,
    output logic            ovf
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               s1;
    logic               s2;
    logic               s3;
    logic               rise;
    logic               fall;
    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W:0]     cnt_inc;
    logic               gen;
    logic [1:0]         gen_code;
    logic               div_restart;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign tick    = (div == DIV_W'(TICK_DIV - 1));
    assign cnt_inc = (CNT_W + 1)'(cnt) + (CNT_W + 1)'(1);

    // Synchronize the key level and keep one cycle of history for edges.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Tick divider; realigned to the press so tick k lands k*TICK_DIV after it.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            div <= '0;
        end else if (div_restart || tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // State register, hold counter and registered held flag.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            held  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            held  <= (state_next != ST_IDLE);
        end
    end

    // Next-state logic; a release always wins over a coincident tick.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end else if (tick && (cnt_inc == (CNT_W + 1)'(LONG_TICKS))) begin
                    state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Event generation, hold counter update and divider realignment.
    always_comb begin
        gen         = 1'b0;
        gen_code    = EV_PRESS;
        cnt_next    = cnt;
        div_restart = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rise) begin
                    gen         = 1'b1;
                    gen_code    = EV_PRESS;
                    cnt_next    = '0;
                    div_restart = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    gen      = 1'b1;
                    gen_code = EV_RELEASE;
                end else if (tick) begin
                    if (cnt_inc == (CNT_W + 1)'(LONG_TICKS)) begin
                        gen      = 1'b1;
                        gen_code = EV_LONG;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            ST_HELD: begin
                if (fall) begin
                    gen      = 1'b1;
                    gen_code = EV_RELEASE;
                end else if (tick) begin
                    if (cnt_inc == (CNT_W + 1)'(REPEAT_TICKS)) begin
                        gen      = 1'b1;
                        gen_code = EV_REPEAT;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    // Single-entry event register; a blocked event is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            ev.ev_valid <= 1'b0;
            ev.ev_code  <= 2'b00;
            ovf         <= 1'b0;
        end else begin
            if (gen && (!ev.ev_valid || ev.ev_ready)) begin
                ev.ev_valid <= 1'b1;
                ev.ev_code  <= gen_code;
            end else if (ev.ev_valid && ev.ev_ready) begin
                ev.ev_valid <= 1'b0;
            end
            if (gen && ev.ev_valid && !ev.ev_ready) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Randomized check of key_event against a timeline-based reference model.
module tb_key_event;

    localparam int unsigned TD  = 4;
    localparam int unsigned LT  = 3;
    localparam int unsigned RT  = 2;

    logic clk;
    logic clr_n;
    logic key;
    logic ovf_clr;
    logic held;
    logic ovf;

    key_event_if bus ();

    key_event #(
        .TICK_DIV     (TD),
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .i       (key),
        .ovf_clr (ovf_clr),
        .ev      (bus.master),
        .held    (held),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: key level history, press timestamp, event register.
    bit       hist[$];
    bit       m_down;
    int       m_tp;
    bit       m_valid;
    bit [1:0] m_code;
    bit       m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_edge();
        bit       lvl;
        bit       prv;
        bit       gen;
        bit [1:0] code;
        int       el;
        int       t;
        cyc++;
        if (!clr_n) begin
            m_down  = 1'b0;
            m_valid = 1'b0;
            m_code  = 2'b00;
            m_ovf   = 1'b0;
            hist    = '{1'b0, 1'b0, 1'b0};
            return;
        end
        lvl  = hist[hist.size()-2];
        prv  = hist[hist.size()-3];
        gen  = 1'b0;
        code = 2'b00;
        if (!m_down) begin
            if (lvl && !prv) begin
                gen    = 1'b1;
                code   = 2'b00;
                m_down = 1'b1;
                m_tp   = cyc;
            end
        end else if (!lvl && prv) begin
            gen    = 1'b1;
            code   = 2'b01;
            m_down = 1'b0;
        end else begin
            el = cyc - m_tp;
            if (el > 0 && (el % TD) == 0) begin
                t = el / TD;
                if (t == LT) begin
                    gen  = 1'b1;
                    code = 2'b10;
                end else if (t > LT && ((t - LT) % RT) == 0) begin
                    gen  = 1'b1;
                    code = 2'b11;
                end
            end
        end
        if (gen && m_valid && !bus.ev_ready) begin
            m_ovf = 1'b1;
        end else if (ovf_clr) begin
            m_ovf = 1'b0;
        end
        if (gen && (!m_valid || bus.ev_ready)) begin
            m_valid = 1'b1;
            m_code  = code;
        end else if (m_valid && bus.ev_ready) begin
            m_valid = 1'b0;
        end
        hist.push_back(key);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ev_valid", 32'(bus.ev_valid), 32'(m_valid));
        check("ev_code",  32'(bus.ev_code),  32'(m_code));
        check("held",     32'(held),         32'(m_down));
        check("ovf",      32'(ovf),          32'(m_ovf));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        hist         = '{1'b0, 1'b0, 1'b0};
        m_down       = 1'b0;
        m_tp         = 0;
        m_valid      = 1'b0;
        m_code       = 2'b00;
        m_ovf        = 1'b0;
        clr_n        = 1'b0;
        key          = 1'b0;
        ovf_clr      = 1'b0;
        bus.ev_ready = 1'b1;
        run(2);
        clr_n = 1'b1;
        run(3);

        // Long hold: press, long, repeats, then release.
        key = 1'b1; run(40);
        key = 1'b0; run(10);

        // Short pulse: press then release, no long.
        key = 1'b1; run(6);
        key = 1'b0; run(10);

        // Backpressure: release dropped, overflow then cleared.
        bus.ev_ready = 1'b0;
        key = 1'b1; run(6);
        key = 1'b0; run(8);
        ovf_clr = 1'b1; run(1);
        ovf_clr = 1'b0; run(2);
        bus.ev_ready = 1'b1; run(3);

        // Release landing on the long-press tick (PRESS at edge 3, tick 3 at +12).
        key = 1'b1; run(12);
        key = 1'b0; run(10);

        // Reset while held: no release, fresh press afterwards.
        key = 1'b1; run(25);
        clr_n = 1'b0; run(1);
        clr_n = 1'b1; run(10);
        key = 1'b0; run(8);

        // Randomized presses with random backpressure, clears and resets.
        for (int it = 0; it < 60; it++) begin
            int hi;
            int lo;
            hi  = int'($urandom_range(1, 50));
            lo  = int'($urandom_range(1, 20));
            key = 1'b1;
            for (int j = 0; j < hi + lo; j++) begin
                if (j == hi) key = 1'b0;
                bus.ev_ready = ($urandom_range(0, 3) != 0);
                ovf_clr      = ($urandom_range(0, 19) == 0);
                clr_n        = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        clr_n = 1'b1; ovf_clr = 1'b0; bus.ev_ready = 1'b1;
        key = 1'b0; run(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
